song_sequencer: RTL

Sequencer that steps through a song stored in an external synchronous note/duration ROM. It times each note in beats and drives the tone generator with a note code and a gate. It sits between the top-level game/audio control (play/stop/loop) and the sine tone generator. The tone generator uses the note code to select its pitch limit and produces sound only while the gate is high.

---
 rtl/song_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - beat-timed song sequencer driving a tone generator from a note/duration ROM
//
// Steps through a song held in an external synchronous ROM. Each entry gives a
// note code and a duration code. The note plays for (dur+1) beats and is
// followed by a short silent gap. A rest code keeps the gate low for the
// note's duration. An end code finishes the song, or restarts it when looping.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   play       start request, level-sampled, honoured only while idle
//   stop       abort request, honoured in every non-idle state
//   loop_en    sampled at end of song: 1 = restart at entry 0
//   rom_addr   registered ROM read address
//   rom_note   ROM note data, valid one cycle after rom_addr
//   rom_dur    ROM duration data, valid one cycle after rom_addr
//   note_code  current note code to the tone generator
//   note_gate  1 = tone generator enabled
//   busy       1 in every state except idle
//   done       one-cycle pulse on a natural song end
module song_sequencer #(
  parameter int SONG_LENGTH = 128,
  parameter int NOTE_WIDTH  = 4,
  parameter int DUR_WIDTH   = 3,
  parameter int BEAT_DIV    = 6250000,
  parameter int GAP_CYCLES  = 2,
  parameter int REST_CODE   = 11,
  parameter int END_CODE    = 15
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           play,
  input  logic                           stop,
  input  logic                           loop_en,
  output logic [$clog2(SONG_LENGTH)-1:0] rom_addr,
  input  logic [NOTE_WIDTH-1:0]          rom_note,
  input  logic [DUR_WIDTH-1:0]           rom_dur,
  output logic [NOTE_WIDTH-1:0]          note_code,
  output logic                           note_gate,
  output logic                           busy,
  output logic                           done
);

  localparam int AW = $clog2(SONG_LENGTH);
  localparam int CW = $clog2(BEAT_DIV) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  localparam logic [AW-1:0]         ADDR_LAST = AW'(SONG_LENGTH - 1);
  localparam logic [CW-1:0]         CYC_LAST  = CW'(BEAT_DIV - 1);
  localparam logic [GW-1:0]         GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NOTE_WIDTH-1:0] REST_NOTE = NOTE_WIDTH'(REST_CODE);
  localparam logic [NOTE_WIDTH-1:0] END_NOTE  = NOTE_WIDTH'(END_CODE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cyc, cyc_nxt;
  logic [DUR_WIDTH-1:0]  beat, beat_nxt;
  logic [DUR_WIDTH-1:0]  dur, dur_nxt;
  logic [GW-1:0]         gcnt, gcnt_nxt;
  logic [AW-1:0]         addr_nxt;
  logic [NOTE_WIDTH-1:0] code_nxt;
  logic                  gate_nxt;

  // Where a finished note goes next: shared by the gap exit and by the
  // last play cycle when there is no gap.
  state_t                exit_state;
  logic [AW-1:0]         exit_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      note_code <= '0;
      note_gate <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cyc       <= '0;
      beat      <= '0;
      dur       <= '0;
      gcnt      <= '0;
    end else begin
      state     <= state_nxt;
      rom_addr  <= addr_nxt;
      note_code <= code_nxt;
      note_gate <= gate_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      cyc       <= cyc_nxt;
      beat      <= beat_nxt;
      dur       <= dur_nxt;
      gcnt      <= gcnt_nxt;
    end
  end

  always_comb begin
    exit_state = S_DONE;
    exit_addr  = rom_addr;
    if (rom_addr != ADDR_LAST) begin
      exit_state = S_FETCH;
      exit_addr  = rom_addr + 1'b1;
    end else if (loop_en) begin
      exit_state = S_FETCH;
      exit_addr  = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    code_nxt  = note_code;
    gate_nxt  = note_gate;
    cyc_nxt   = cyc;
    beat_nxt  = beat;
    dur_nxt   = dur;
    gcnt_nxt  = gcnt;

    case (state)
      S_IDLE: begin
        gate_nxt = 1'b0;
        if (play && !stop) begin
          state_nxt = S_FETCH;
          addr_nxt  = '0;
        end
      end

      S_FETCH: begin
        state_nxt = S_LOAD;
      end

      S_LOAD: begin
        if (rom_note == END_NOTE) begin
          // An end marker at entry 0 would loop forever without playing
          // anything, so it always terminates.
          if (loop_en && (rom_addr != '0)) begin
            state_nxt = S_FETCH;
            addr_nxt  = '0;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          state_nxt = S_PLAY;
          code_nxt  = rom_note;
          gate_nxt  = (rom_note != REST_NOTE);
          dur_nxt   = rom_dur;
          cyc_nxt   = '0;
          beat_nxt  = '0;
        end
      end

      S_PLAY: begin
        if (cyc == CYC_LAST) begin
          cyc_nxt = '0;
          if (beat == dur) begin
            gate_nxt = 1'b0;
            beat_nxt = '0;
            if (GAP_CYCLES == 0) begin
              state_nxt = exit_state;
              addr_nxt  = exit_addr;
            end else begin
              state_nxt = S_GAP;
              gcnt_nxt  = '0;
            end
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end else begin
          cyc_nxt = cyc + 1'b1;
        end
      end

      S_GAP: begin
        gate_nxt = 1'b0;
        if (gcnt == GAP_LAST) begin
          gcnt_nxt  = '0;
          state_nxt = exit_state;
          addr_nxt  = exit_addr;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end

      S_DONE: begin
        gate_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        gate_nxt  = 1'b0;
      end
    endcase

    // Abort overrides whatever the state decided, including a note load
    // in progress; address and note code keep their last values.
    if (stop && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      addr_nxt  = rom_addr;
      code_nxt  = note_code;
      gate_nxt  = 1'b0;
      cyc_nxt   = '0;
      beat_nxt  = '0;
      gcnt_nxt  = '0;
    end
  end

endmodule
